// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, jump control, FSM states.
package exec_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned REG_W  = 4;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_SHR  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    JMP_NONE   = 2'b00,
    JMP_ALWAYS = 2'b01,
    JMP_ZERO   = 2'b10,
    JMP_NZERO  = 2'b11
  } jctl_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_e;

  function automatic logic jump_cond(input jctl_e j, input logic zero);
    logic taken;
    taken = 1'b0;
    case (j)
      JMP_ALWAYS: taken = 1'b1;
      JMP_ZERO:   taken = zero;
      JMP_NZERO:  taken = ~zero;
      default:    taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU; result truncated to 16 bits, zero flag on result.
module alu16
  import exec_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_ctl,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (alu_op_e'(alu_ctl))
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SHL:  result = a << b[3:0];
      ALU_SHR:  result = a >> b[3:0];
      ALU_PASS: result = b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU/jump resolution and a two-state data-memory handshake.
// Optional MEM timeout with sticky err is enabled by defining EXEC_TIMEOUT_EN.
module execute_stage
  import exec_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a_val,
  input  logic [DATA_W-1:0] b_val,
  input  logic [REG_W-1:0]  c_addr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        alu_ctl,
  input  logic [1:0]        JCTL,
  input  logic              data_read,
  input  logic              data_write,
  input  logic              reg_addr,
  input  logic              reg_write,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              jump_taken,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              err
);

  if (MEM_TIMEOUT == 0 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be within 1..255");
  end

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                wb_en_q, wb_en_d;
  logic [REG_W-1:0]    wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                jump_taken_q, jump_taken_d;
  logic [ADDR_W-1:0]   jump_addr_q, jump_addr_d;
  logic                pend_wb_q, pend_wb_d;
  logic [REG_W-1:0]    pend_addr_q, pend_addr_d;

  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;
  logic                mem_op;
  logic [ADDR_W-1:0]   eff_addr;

  alu16 u_alu (
    .a       (a_val),
    .b       (b_val),
    .alu_ctl (alu_ctl),
    .result  (alu_result),
    .zero    (alu_zero)
  );

  assign mem_op   = data_read | data_write;
  assign eff_addr = reg_addr ? a_val[ADDR_W-1:0] : addr;
  assign stall    = (state_q == ST_MEM) || (valid_in && mem_op);

`ifdef EXEC_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wb_en_d      = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    jump_taken_d = 1'b0;
    jump_addr_d  = jump_addr_q;
    pend_wb_d    = pend_wb_q;
    pend_addr_d  = pend_addr_q;
`ifdef EXEC_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (valid_in && mem_op) begin
          state_d     = ST_MEM;
          mem_req_d   = 1'b1;
          mem_we_d    = data_write;
          mem_addr_d  = eff_addr;
          mem_wdata_d = b_val;
          // Writeback eligibility is resolved now so the MEM state only needs a flag.
          pend_wb_d   = reg_write && !data_write && (c_addr != '0);
          pend_addr_d = c_addr;
`ifdef EXEC_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end else if (valid_in) begin
          wb_en_d      = reg_write && (c_addr != '0);
          wb_addr_d    = c_addr;
          wb_data_d    = alu_result;
          jump_taken_d = jump_cond(jctl_e'(JCTL), alu_zero);
          jump_addr_d  = addr;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wb_en_d   = pend_wb_q;
          if (!mem_we_q) begin
            wb_addr_d = pend_addr_q;
            wb_data_d = mem_rdata;
          end
        end
`ifdef EXEC_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      jump_taken_q <= 1'b0;
      jump_addr_q  <= '0;
      pend_wb_q    <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_en_q      <= wb_en_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      jump_taken_q <= jump_taken_d;
      jump_addr_q  <= jump_addr_d;
      pend_wb_q    <= pend_wb_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

`ifdef EXEC_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wb_en      = wb_en_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign jump_taken = jump_taken_q;
  assign jump_addr  = jump_addr_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage; timeout checks follow EXEC_TIMEOUT_EN.
module tb_execute_stage;

  localparam int unsigned TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        valid_in;
  logic [15:0] a_val, b_val;
  logic [3:0]  c_addr;
  logic [7:0]  addr;
  logic [2:0]  alu_ctl;
  logic [1:0]  JCTL;
  logic        data_read, data_write, reg_addr, reg_write;
  logic        stall, mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        jump_taken;
  logic [7:0]  jump_addr;
  logic        err;

  int total = 0;
  int bad   = 0;

  execute_stage #(.MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .valid_in(valid_in), .a_val(a_val), .b_val(b_val),
    .c_addr(c_addr), .addr(addr), .alu_ctl(alu_ctl), .JCTL(JCTL),
    .data_read(data_read), .data_write(data_write), .reg_addr(reg_addr),
    .reg_write(reg_write), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .jump_taken(jump_taken), .jump_addr(jump_addr), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    valid_in = 0; a_val = 0; b_val = 0; c_addr = 0; addr = 0; alu_ctl = 0;
    JCTL = 0; data_read = 0; data_write = 0; reg_addr = 0; reg_write = 0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b;
    logic [3:0]  c;
    logic        rw;
    logic [1:0]  j;
    logic [7:0]  ad;
    logic        e_wb;
    logic [15:0] e_data;
    logic        e_jmp;
  } vec_t;

  vec_t vecs[$];
  int   stall_cnt, req_cnt;
  logic wb_seen;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back('{3'b000, 16'hFFFF, 16'h0002, 4'd3, 1'b1, 2'b00, 8'h00, 1'b1, 16'h0001, 1'b0});
    vecs.push_back('{3'b001, 16'h0005, 16'h0007, 4'd1, 1'b1, 2'b00, 8'h00, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{3'b010, 16'hF0F0, 16'hFF00, 4'd2, 1'b1, 2'b00, 8'h00, 1'b1, 16'hF000, 1'b0});
    vecs.push_back('{3'b011, 16'h00F0, 16'h0F00, 4'd4, 1'b1, 2'b00, 8'h00, 1'b1, 16'h0FF0, 1'b0});
    vecs.push_back('{3'b100, 16'hA5A5, 16'hFFFF, 4'd5, 1'b1, 2'b00, 8'h00, 1'b1, 16'h5A5A, 1'b0});
    vecs.push_back('{3'b101, 16'h0001, 16'h0014, 4'd6, 1'b1, 2'b00, 8'h00, 1'b1, 16'h0010, 1'b0});
    vecs.push_back('{3'b110, 16'h8000, 16'h000F, 4'd7, 1'b1, 2'b00, 8'h00, 1'b1, 16'h0001, 1'b0});
    vecs.push_back('{3'b111, 16'h9999, 16'h1234, 4'd8, 1'b1, 2'b00, 8'h00, 1'b1, 16'h1234, 1'b0});
    vecs.push_back('{3'b000, 16'h0001, 16'h0001, 4'd0, 1'b1, 2'b00, 8'h00, 1'b0, 16'h0002, 1'b0});
    vecs.push_back('{3'b000, 16'h0003, 16'h0001, 4'd9, 1'b0, 2'b00, 8'h00, 1'b0, 16'h0004, 1'b0});
    vecs.push_back('{3'b001, 16'h0007, 16'h0007, 4'd1, 1'b0, 2'b10, 8'h80, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{3'b001, 16'h0008, 16'h0007, 4'd1, 1'b0, 2'b10, 8'h80, 1'b0, 16'h0001, 1'b0});
    vecs.push_back('{3'b001, 16'h0008, 16'h0007, 4'd1, 1'b0, 2'b11, 8'h44, 1'b0, 16'h0001, 1'b1});
    vecs.push_back('{3'b001, 16'h0007, 16'h0007, 4'd1, 1'b0, 2'b11, 8'h44, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{3'b000, 16'h0000, 16'h0001, 4'd1, 1'b0, 2'b01, 8'h33, 1'b0, 16'h0001, 1'b1});

    clr_in();
    RST = 1; mem_ack = 0; mem_rdata = 0;
    step(); step();
    @(negedge CLK);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_jump", jump_taken, 0);
    chk("rst_err", err, 0);
    step();
    RST = 0;

    foreach (vecs[i]) begin
      clr_in();
      valid_in = 1; alu_ctl = vecs[i].op; a_val = vecs[i].a; b_val = vecs[i].b;
      c_addr = vecs[i].c; reg_write = vecs[i].rw; JCTL = vecs[i].j; addr = vecs[i].ad;
      @(negedge CLK);
      chk($sformatf("alu%0d_stall", i), stall, 0);
      step();
      clr_in();
      @(negedge CLK);
      chk($sformatf("alu%0d_wb_en", i), wb_en, vecs[i].e_wb);
      if (vecs[i].rw) begin
        chk($sformatf("alu%0d_wb_addr", i), wb_addr, vecs[i].c);
        chk($sformatf("alu%0d_wb_data", i), wb_data, vecs[i].e_data);
      end
      chk($sformatf("alu%0d_jump", i), jump_taken, vecs[i].e_jmp);
      if (vecs[i].e_jmp) chk($sformatf("alu%0d_jaddr", i), jump_addr, vecs[i].ad);
      step();
      @(negedge CLK);
      chk($sformatf("alu%0d_wb_drop", i), wb_en, 0);
      chk($sformatf("alu%0d_jump_drop", i), jump_taken, 0);
    end

    // Read: three MEM cycles, ack on the third.
    clr_in();
    valid_in = 1; data_read = 1; addr = 8'h40; a_val = 16'h0012; c_addr = 4'd5;
    reg_write = 1; JCTL = 2'b01;
    stall_cnt = 0;
    @(negedge CLK);
    if (stall) stall_cnt++;
    chk("rd_stall_idle", stall, 1);
    step();
    clr_in();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (stall) stall_cnt++;
      chk($sformatf("rd_req%0d", k), mem_req, 1);
      chk($sformatf("rd_addr%0d", k), mem_addr, 8'h40);
      chk($sformatf("rd_we%0d", k), mem_we, 0);
      chk($sformatf("rd_wb_idle%0d", k), wb_en, 0);
      chk($sformatf("rd_nojump%0d", k), jump_taken, 0);
      if (k == 2) begin mem_ack = 1; mem_rdata = 16'hBEEF; end
      step();
    end
    mem_ack = 0; mem_rdata = 0;
    @(negedge CLK);
    if (stall) stall_cnt++;
    chk("rd_req_drop", mem_req, 0);
    chk("rd_wb_en", wb_en, 1);
    chk("rd_wb_addr", wb_addr, 5);
    chk("rd_wb_data", wb_data, 16'hBEEF);
    chk("rd_stall_cnt", stall_cnt, 4);

    // Write wins over read, address from register, jump ignored.
    step();
    clr_in();
    valid_in = 1; data_write = 1; data_read = 1; reg_addr = 1; a_val = 16'h0012;
    b_val = 16'h5A5A; addr = 8'h99; c_addr = 4'd2; reg_write = 1; JCTL = 2'b01;
    wb_seen = 0;
    step();
    clr_in();
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      wb_seen |= wb_en;
      chk($sformatf("wr_req%0d", k), mem_req, 1);
      chk($sformatf("wr_we%0d", k), mem_we, 1);
      chk($sformatf("wr_addr%0d", k), mem_addr, 8'h12);
      chk($sformatf("wr_wdata%0d", k), mem_wdata, 16'h5A5A);
      chk($sformatf("wr_nojump%0d", k), jump_taken, 0);
      if (k == 1) mem_ack = 1;
      step();
    end
    mem_ack = 0;
    @(negedge CLK);
    wb_seen |= wb_en;
    chk("wr_req_drop", mem_req, 0);
    step();
    @(negedge CLK);
    wb_seen |= wb_en;
    chk("wr_no_wb", wb_seen, 0);

    // MEM with no ack.
    step();
    clr_in();
    valid_in = 1; data_read = 1; addr = 8'h21; c_addr = 4'd4; reg_write = 1;
    req_cnt = 0;
    step();
    clr_in();
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (mem_req) req_cnt++;
      step();
    end
`ifdef EXEC_TIMEOUT_EN
    chk("tmo_req_cycles", req_cnt, TMO);
    @(negedge CLK);
    chk("tmo_err", err, 1);
    chk("tmo_stall", stall, 0);
    mem_ack = 1; mem_rdata = 16'h7777;
    step();
    mem_ack = 0;
    @(negedge CLK);
    chk("tmo_idle_ack_wb", wb_en, 0);
    chk("tmo_err_held", err, 1);
    RST = 1;
    step();
    RST = 0;
    @(negedge CLK);
    chk("tmo_err_cleared", err, 0);
`else
    chk("notmo_req_cycles", req_cnt, 10);
    @(negedge CLK);
    chk("notmo_err", err, 0);
    chk("notmo_stall", stall, 1);
    mem_ack = 1; mem_rdata = 16'h7777;
    step();
    mem_ack = 0;
    @(negedge CLK);
    chk("notmo_req_drop", mem_req, 0);
    chk("notmo_wb_data", wb_data, 16'h7777);
`endif

    // Reset while in MEM discards the pending read.
    step();
    clr_in();
    valid_in = 1; data_read = 1; addr = 8'h55; c_addr = 4'd6; reg_write = 1;
    step();
    clr_in();
    @(negedge CLK);
    chk("rstm_req", mem_req, 1);
    RST = 1;
    step();
    RST = 0;
    @(negedge CLK);
    chk("rstm_req_drop", mem_req, 0);
    chk("rstm_stall", stall, 0);
    mem_ack = 1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 0;
    wb_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      wb_seen |= wb_en;
      step();
    end
    chk("rstm_no_wb", wb_seen, 0);
    chk("rstm_wb_data", wb_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max cycles mem_req waits for mem_ack (range 1..255).
REQ-002 SHALL have port CLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid_in  in  1  decode bundle valid this cycle.
REQ-005 SHALL have ports a_val, b_val  in  16 each  operands.
REQ-006 SHALL have port c_addr  in  4  destination register.
REQ-007 SHALL have port addr  in  8  memory/jump address.
REQ-008 SHALL have port alu_ctl  in  3  ALU op.
REQ-009 SHALL have port JCTL  in  2  jump control.
REQ-010 SHALL have ports data_read, data_write, reg_addr, reg_write  in  1 each  memory read, memory write, address-from-register select, writeback enable.
REQ-011 SHALL have port stall  out  1  upstream must hold the bundle.
REQ-012 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 8, mem_wdata out 16, mem_rdata in 16, mem_ack in 1  data-memory handshake.
REQ-013 SHALL have ports wb_en out 1, wb_addr out 4, wb_data out 16  register-file write.
REQ-014 SHALL have ports jump_taken out 1, jump_addr out 8  branch redirect.
REQ-015 SHALL have port err  out  1  sticky memory-timeout flag.

Function
REQ-016 SHALL implement alu_ctl: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL by b_val[3:0], 110 SHR logical by b_val[3:0], 111 PASS b_val; results truncated to 16 bits, carry discarded.
REQ-017 SHALL use FSM states IDLE, MEM; bundle accepted only in IDLE with valid_in=1.
REQ-018 SHALL treat a bundle as memory op when data_read or data_write is 1; data_write wins when both set (read ignored).
REQ-019 SHALL drive effective address = a_val[7:0] when reg_addr=1, else addr.
REQ-020 SHALL, for a non-memory bundle accepted at edge N, register wb_en=reg_write, wb_addr=c_addr, wb_data=ALU result, valid during cycle N+1 (latency 1), staying in IDLE.
REQ-021 SHALL, for a memory bundle accepted at edge N, enter MEM and hold mem_req=1, mem_we, mem_addr, mem_wdata=b_val stable from cycle N+1 until the edge sampling mem_ack=1.
REQ-022 SHALL, on mem_ack at edge M, drop mem_req in cycle M+1, return to IDLE, and for reads pulse wb_en=reg_write with wb_data=mem_rdata sampled at M; writes produce wb_en=0.
REQ-023 SHALL assert stall combinationally = (state==MEM) or (state==IDLE and valid_in and memory op).
REQ-024 SHALL suppress wb_en when wb_addr would be 0 (r0 read-only).
REQ-025 SHALL decode JCTL: 00 none, 01 always, 10 if ALU result==0, 11 if result!=0; jump_taken one-cycle pulse in cycle N+1, jump_addr=addr; JCTL ignored for memory ops.
REQ-026 SHALL deassert wb_en and jump_taken every cycle not covered by REQ-020/022/025.
REQ-027 SHALL ignore mem_ack while in IDLE.

Reset
REQ-028 SHALL, on RST=1 at a rising edge, force state IDLE and all outputs 0 (stall driven by REQ-023 from IDLE), err cleared, timeout counter 0.
REQ-029 SHALL, on reset mid-MEM, drop mem_req next cycle and discard the pending op with no writeback.

Configuration
REQ-030 SHALL, with EXEC_TIMEOUT_EN defined, count MEM cycles; when MEM_TIMEOUT cycles elapse without mem_ack, drop mem_req, return to IDLE, no writeback, set err until reset.
REQ-031 SHALL, without EXEC_TIMEOUT_EN, wait indefinitely in MEM, omit the counter, tie err to 0.

Structure
REQ-032 SHALL place alu_ctl encodings, JCTL encodings and FSM state encoding in shared package exec_pkg.
REQ-033 SHALL instantiate combinational sub-module alu16 (a, b, alu_ctl -> result, zero).

Verification
REQ-034 SHALL test ADD: a=0xFFFF, b=0x0002, c_addr=3, reg_write=1 -> next cycle wb_en=1, wb_addr=3, wb_data=0x0001.
REQ-035 SHALL test read: data_read=1, addr=0x40, mem_ack after 3 cycles with rdata=0xBEEF -> stall high 4 cycles, mem_addr=0x40, then wb_data=0xBEEF.
REQ-036 SHALL test write with reg_addr=1, a=0x0012, b=0x5A5A -> mem_we=1, mem_addr=0x12, mem_wdata=0x5A5A, wb_en never set.
REQ-037 SHALL test JCTL=10, SUB a=b=7, addr=0x80 -> jump_taken=1, jump_addr=0x80; same with a=8 -> jump_taken=0.
REQ-038 SHALL test with EXEC_TIMEOUT_EN, MEM_TIMEOUT=4, no ack -> mem_req drops after 4 cycles, err=1, held until RST.
REQ-039 SHALL test RST asserted in MEM -> mem_req=0 next cycle, later mem_ack ignored, no wb_en.
